uart_tx_fifo: RTL

Parametrised UART transmitter with an input FIFO, configurable frame format (data width, parity mode, stop bits) and an internal oversampled baud tick generator. It accepts words from the host over a valid/ready handshake and serialises them LSB-first on `txd`. It replaces the fixed 8-bit, even-parity transmitter in the UART subsystem and pairs with the existing receiver on the same `baud_select` encoding.

---
 rtl/uart_pkg.sv | 42 ++++
 rtl/uart_tx_fifo_if.sv | 11 +
 rtl/uart_baud_tick.sv | 25 ++
 rtl/uart_tx_fifo.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity and FSM encodings, the baud table and the
// divisor rounding used by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10,
        PAR_MARK = 2'b11
    } parity_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    // Indexed by baud_select.
    localparam int unsigned BAUD_RATE [8] = '{300, 1200, 4800, 9600, 19200, 38400, 57600, 115200};

    // Clocks per oversample tick, rounded to nearest.
    function automatic int unsigned baud_divisor(input int unsigned clk_hz,
                                                 input int unsigned rate,
                                                 input int unsigned oversample);
        int unsigned den;
        den = rate * oversample;
        return (clk_hz + den / 2) / den;
    endfunction

    function automatic logic parity_bit(input parity_e mode, input logic data_xor);
        logic p;
        case (mode)
            PAR_EVEN: p = data_xor;
            PAR_ODD:  p = ~data_xor;
            default:  p = 1'b1;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Host-side valid/ready write port of the UART transmitter.
interface uart_tx_fifo_if #(
    parameter int DATA_BITS = 8
) ();
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_baud_tick.sv
// Free-running clock divider producing a one-cycle tick every `divisor` clocks;
// `restart` realigns the count so a new frame begins on a full period.
module uart_baud_tick #(
    parameter int DIV_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             restart,
    input  logic [DIV_W-1:0] divisor,
    output logic             tick
);
    logic [DIV_W-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == divisor - DIV_W'(1));

    always_comb begin
        cnt_d = cnt_q + DIV_W'(1);
        if (restart || tick) cnt_d = '0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with an inline circular FIFO, runtime-selectable frame
// format and baud rate latched per frame.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int          DATA_BITS  = 8,
    parameter int          OVERSAMPLE = 16,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [2:0]                    baud_select,
    input  logic [1:0]                    parity_mode,
    input  logic                          stop_two,
    input  logic                          tx_en,
    uart_tx_fifo_if.slave                 host,
    output logic                          txd,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LVL_W = AW + 1;
    localparam int OS_W  = $clog2(OVERSAMPLE);
    localparam int BC_W  = $clog2(DATA_BITS);
    localparam int unsigned DIVS [8] = '{
        baud_divisor(CLK_HZ, BAUD_RATE[0], OVERSAMPLE),
        baud_divisor(CLK_HZ, BAUD_RATE[1], OVERSAMPLE),
        baud_divisor(CLK_HZ, BAUD_RATE[2], OVERSAMPLE),
        baud_divisor(CLK_HZ, BAUD_RATE[3], OVERSAMPLE),
        baud_divisor(CLK_HZ, BAUD_RATE[4], OVERSAMPLE),
        baud_divisor(CLK_HZ, BAUD_RATE[5], OVERSAMPLE),
        baud_divisor(CLK_HZ, BAUD_RATE[6], OVERSAMPLE),
        baud_divisor(CLK_HZ, BAUD_RATE[7], OVERSAMPLE)
    };
    localparam int DIV_W = $clog2(DIVS[0] + 1);

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]          wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]     level_q, level_d;
    logic                 push, pop, fifo_empty;

    tx_state_e            state_q;
    logic                 txd_q, busy_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_q;
    parity_e              par_mode_q;
    logic                 stop_two_q, stop_cnt_q;
    logic [BC_W-1:0]      bit_cnt_q;
    logic [OS_W-1:0]      os_q;
    logic [DIV_W-1:0]     div_q;
    logic                 tick, bit_done, last_stop, can_start, start_frame;

    assign host.tx_ready = (level_q != LVL_W'(FIFO_DEPTH));
    assign push          = host.tx_valid && host.tx_ready;
    assign fifo_empty    = (wr_ptr_q == rd_ptr_q);
    assign can_start     = tx_en && !fifo_empty;
    assign bit_done      = tick && (os_q == OS_W'(OVERSAMPLE - 1));
    assign last_stop     = bit_done && (state_q == ST_STOP) && (!stop_two_q || stop_cnt_q);
    // A new frame may start from IDLE or straight out of the final stop bit.
    assign start_frame   = can_start && ((state_q == ST_IDLE) || last_stop);
    assign pop           = start_frame;

    assign txd        = txd_q;
    assign tx_busy    = busy_q;
    assign fifo_level = level_q;

    uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
        .clock   (clock),
        .reset   (reset),
        .restart (start_frame),
        .divisor (div_q),
        .tick    (tick)
    );

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= host.tx_data;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            level_q <= level_d;
        end
    end

    // Word and its parity are captured at frame start so later writes cannot disturb them.
    always_ff @(posedge clock) begin
        if (start_frame) begin
            shift_q <= mem_q[rd_ptr_q[AW-1:0]];
            par_q   <= parity_bit(parity_e'(parity_mode), ^mem_q[rd_ptr_q[AW-1:0]]);
        end else if (bit_done && (state_q == ST_START || state_q == ST_DATA)) begin
            shift_q <= shift_q >> 1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            os_q       <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            par_mode_q <= PAR_NONE;
            stop_two_q <= 1'b0;
            div_q      <= DIV_W'(DIVS[7]);
        end else begin
            if (bit_done)  os_q <= '0;
            else if (tick) os_q <= os_q + OS_W'(1);

            if (start_frame) begin
                state_q    <= ST_START;
                txd_q      <= 1'b0;
                busy_q     <= 1'b1;
                os_q       <= '0;
                par_mode_q <= parity_e'(parity_mode);
                stop_two_q <= stop_two;
                div_q      <= DIV_W'(DIVS[baud_select]);
            end else if (bit_done) begin
                case (state_q)
                    ST_IDLE: ;
                    ST_START: begin
                        state_q   <= ST_DATA;
                        txd_q     <= shift_q[0];
                        bit_cnt_q <= '0;
                    end
                    ST_DATA: begin
                        if (bit_cnt_q == BC_W'(DATA_BITS - 1)) begin
                            if (par_mode_q == PAR_NONE) begin
                                state_q    <= ST_STOP;
                                txd_q      <= 1'b1;
                                stop_cnt_q <= 1'b0;
                            end else begin
                                state_q <= ST_PARITY;
                                txd_q   <= par_q;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BC_W'(1);
                            txd_q     <= shift_q[0];
                        end
                    end
                    ST_PARITY: begin
                        state_q    <= ST_STOP;
                        txd_q      <= 1'b1;
                        stop_cnt_q <= 1'b0;
                    end
                    ST_STOP: begin
                        if (last_stop) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            stop_cnt_q <= 1'b1;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end
endmodule
